// File: rtl/seq_pkg.sv
// Shared types for the multi-cycle RV32I sequencer.
// Contains the 3-bit state encoding and the branch-type codes that select the PC target.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERR    = 3'd6
  } seq_state_e;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JUMP = 3'b111;

  // Jumps always redirect; conditional branches redirect only when the compare says taken.
  function automatic logic pc_target_sel(input logic [2:0] br_type, input logic br_taken);
    return (br_type == BR_JUMP) || ((br_type != BR_NONE) && br_taken);
  endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Request/ready handshake between the sequencer (master) and the shared
// instruction/data memory (slave).
interface mc_sequencer_if;

  logic mem_req;
  logic mem_we;
  logic mem_is_fetch;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_is_fetch,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_is_fetch,
    output mem_ready
  );

endinterface

// File: rtl/seq_timeout_ctr.sv
// Memory wait-cycle counter: cleared on entry to a memory state, flags expiry on the
// MEM_TIMEOUT-th consecutive wait cycle so the sequencer can trap the next clock.
module seq_timeout_ctr #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  localparam int CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry must not depend on clear_i: clear is derived from the next state, which uses this flag.
  assign expired_o = cnt_en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Define SEQ_TIMEOUT_EN to bound each memory wait by MEM_TIMEOUT and trap into ERR on expiry.
module mc_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              reg_wr_i,
  input  logic              rd_en_i,
  input  logic              wr_en_i,
  input  logic [2:0]        br_type_i,
  input  logic              br_taken_i,
  mc_sequencer_if.master    mem,
  output logic              ir_en,
  output logic              pc_en,
  output logic              pc_sel,
  output logic              rf_we,
  output logic              retire,
  output logic              busy,
  output logic              err,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  instret
);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;
  logic             waitExpired;
  logic             memReq;
  logic             memWe;
  logic             memIsFetch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem.mem_ready)    state_d = ST_DECODE;
        else if (waitExpired) state_d = ST_ERR;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = (rd_en_i || wr_en_i) ? ST_MEM : ST_WB;
      ST_MEM: begin
        // A completed store retires straight from MEM; a load still needs its WB cycle.
        if (mem.mem_ready)    state_d = wr_en_i ? (start ? ST_FETCH : ST_IDLE) : ST_WB;
        else if (waitExpired) state_d = ST_ERR;
      end
      ST_WB:   state_d = start ? ST_FETCH : ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    memReq     = 1'b0;
    memWe      = 1'b0;
    memIsFetch = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = 1'b0;
    rf_we      = 1'b0;
    retire     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        memReq     = 1'b1;
        memIsFetch = 1'b1;
        ir_en      = mem.mem_ready;
      end
      ST_MEM: begin
        memReq = 1'b1;
        memWe  = wr_en_i;
        if (mem.mem_ready && wr_en_i) begin
          pc_en  = 1'b1;
          retire = 1'b1;
        end
      end
      ST_WB: begin
        rf_we  = reg_wr_i;
        pc_en  = 1'b1;
        pc_sel = pc_target_sel(br_type_i, br_taken_i);
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  assign instret_d = retire ? instret_q + 1'b1 : instret_q;

  assign mem.mem_req      = memReq;
  assign mem.mem_we       = memWe;
  assign mem.mem_is_fetch = memIsFetch;
  assign busy             = (state_q != ST_IDLE);
  assign state_o          = state_q;
  assign instret          = instret_q;

`ifdef SEQ_TIMEOUT_EN
  logic waitClear;

  // Any state change restarts the count, so every FETCH/MEM visit gets a fresh budget.
  assign waitClear = (state_d != state_q);

  seq_timeout_ctr #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (waitClear),
    .cnt_en_i  (memReq && !mem.mem_ready),
    .expired_o (waitExpired)
  );

  assign err = (state_q == ST_ERR);
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (MEM_TIMEOUT > 0);
  assign waitExpired        = 1'b0;
  assign err                = 1'b0;
`endif

endmodule
